// File: rtl/iir_mc_pkg.sv
// Shared types and fixed-point helpers for the multi-channel biquad cascade.
// Contents: FSM state enum, coefficient index enum, unity coefficient value,
// saturation helpers and a multiply-then-floor-shift helper. The helpers work
// on 64-bit signed values so one set serves every internal width.
package iir_mc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Coefficient slot within a stage; matches the low three cfg_addr bits.
  typedef enum logic [2:0] {
    C_B0 = 3'd0,
    C_B1 = 3'd1,
    C_B2 = 3'd2,
    C_A1 = 3'd3,
    C_A2 = 3'd4,
    C_G  = 3'd5
  } coef_idx_e;

  localparam int NCOEF      = 6;
  localparam int DEF_CFW    = 14;
  localparam int COEF_UNITY = 1 << DEF_CFW;

  // Clamp v to the signed range of a w-bit value.
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v,
                                                input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // True when sat_fn would change v.
  function automatic logic is_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // Full-precision product, arithmetic shift right (rounds toward -inf).
  function automatic logic signed [63:0] mul_shift(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int sh);
    return (a * b) >>> sh;
  endfunction

endpackage

// File: rtl/iir_mc_biquad_alu.sv
// Combinational single-stage transposed direct-form-II biquad.
// Ports:
//   x, z0, z1           stage input sample and the channel's two state words (W)
//   b0,b1,b2,a1,a2,g    stage coefficients (CW, CFW fraction bits)
//   acc_nx              gained stage output, feeds the next stage (W)
//   z0_nx, z1_nx        updated state words (W)
//   sat                 any intermediate clamped this evaluation
module iir_mc_biquad_alu #(
  parameter int W   = 20,
  parameter int CW  = 18,
  parameter int CFW = 14
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  z0,
  input  logic signed [W-1:0]  z1,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  input  logic signed [CW-1:0] b2,
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  input  logic signed [CW-1:0] g,
  output logic signed [W-1:0]  acc_nx,
  output logic signed [W-1:0]  z0_nx,
  output logic signed [W-1:0]  z1_nx,
  output logic                 sat
);
  import iir_mc_pkg::*;

  // Sums are formed wide enough that nothing wraps ahead of the clamp.
  logic signed [63:0] xw;
  logic signed [63:0] o_raw;
  logic signed [63:0] o_s;
  logic signed [63:0] z0_raw;
  logic signed [63:0] z1_raw;
  logic signed [63:0] acc_raw;

  always_comb begin
    xw      = 64'(x);
    o_raw   = mul_shift(64'(b0), xw, CFW) + 64'(z0);
    o_s     = sat_fn(o_raw, W);
    z0_raw  = mul_shift(64'(b1), xw, CFW) - mul_shift(64'(a1), o_s, CFW) + 64'(z1);
    z1_raw  = mul_shift(64'(b2), xw, CFW) - mul_shift(64'(a2), o_s, CFW);
    acc_raw = mul_shift(64'(g), o_s, CFW);
    z0_nx   = W'(sat_fn(z0_raw, W));
    z1_nx   = W'(sat_fn(z1_raw, W));
    acc_nx  = W'(sat_fn(acc_raw, W));
    sat     = is_sat(o_raw, W) | is_sat(z0_raw, W) | is_sat(z1_raw, W) |
              is_sat(acc_raw, W);
  end

endmodule

// File: rtl/iir_mc_cascade.sv
// Multi-channel biquad cascade: one ALU time-shared over STG stages, with
// per-channel state arrays and runtime-loaded coefficients.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_ch/in_data sample input (accepted when both high)
//   out_valid/out_ch/out_data       one-cycle result pulse, data held after
//   cfg_we/cfg_addr/cfg_data/cfg_err coefficient write port, cfg_err = dropped
//   flush                           clear all channel state, abort in-flight
//   sat_flag                        sticky saturation indicator
//
// state | meaning
// IDLE  | waiting for a sample; config writes are accepted
// RUN   | stepping stage s of the captured sample, one stage per clock
module iir_mc_cascade #(
  parameter int DW  = 16,
  parameter int EW  = 4,
  parameter int CW  = 18,
  parameter int CFW = 14,
  parameter int STG = 3,
  parameter int CH  = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int SW  = (STG > 1) ? $clog2(STG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0] out_data,
  input  logic          cfg_we,
  input  logic [SW+2:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  input  logic          flush,
  output logic          sat_flag
);
  import iir_mc_pkg::*;

  localparam int W = DW + EW;
  localparam logic signed [CW-1:0] UNITY  = CW'(64'sd1 <<< CFW);
  localparam logic [SW-1:0]        S_LAST = SW'(STG - 1);

  state_e state, state_nx;
  logic [SW-1:0]  s;
  logic [CHW-1:0] ch;
  logic           ch_bad;
  logic signed [W-1:0] acc;

  logic signed [W-1:0]  z0   [CH][STG];
  logic signed [W-1:0]  z1   [CH][STG];
  logic signed [CW-1:0] coef [STG][NCOEF];

  logic signed [W-1:0] z0_rd, z1_rd;
  logic signed [W-1:0] acc_nx, z0_nx, z1_nx;
  logic                alu_sat;
  logic                accept;

  logic [SW-1:0] cfg_stage;
  logic [2:0]    cfg_idx;
  logic          cfg_ok;

  assign in_ready  = (state == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign cfg_stage = cfg_addr[SW+2:3];
  assign cfg_idx   = cfg_addr[2:0];
  assign cfg_ok    = (state == ST_IDLE) && (cfg_idx <= 3'd5) && (int'(cfg_stage) < STG);

  // Out-of-range channels run through the ALU against zero state and are
  // never written back.
  assign z0_rd = ch_bad ? '0 : z0[ch][s];
  assign z1_rd = ch_bad ? '0 : z1[ch][s];

  iir_mc_biquad_alu #(.W(W), .CW(CW), .CFW(CFW)) u_alu (
    .x      (acc),
    .z0     (z0_rd),
    .z1     (z1_rd),
    .b0     (coef[s][C_B0]),
    .b1     (coef[s][C_B1]),
    .b2     (coef[s][C_B2]),
    .a1     (coef[s][C_A1]),
    .a2     (coef[s][C_A2]),
    .g      (coef[s][C_G]),
    .acc_nx (acc_nx),
    .z0_nx  (z0_nx),
    .z1_nx  (z1_nx),
    .sat    (alu_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (flush || s == S_LAST) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      ch        <= '0;
      ch_bad    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < STG; k++) begin
          z0[c][k] <= '0;
          z1[c][k] <= '0;
        end
      end
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        // Also aborts a sample in RUN: no write-back, no out_valid.
        sat_flag <= 1'b0;
        for (int c = 0; c < CH; c++) begin
          for (int k = 0; k < STG; k++) begin
            z0[c][k] <= '0;
            z1[c][k] <= '0;
          end
        end
      end else if (accept) begin
        acc    <= W'($signed(in_data));
        ch     <= in_ch;
        ch_bad <= int'(in_ch) >= CH;
        s      <= '0;
      end else if (state == ST_RUN) begin
        acc <= acc_nx;
        if (!ch_bad) begin
          z0[ch][s] <= z0_nx;
          z1[ch][s] <= z1_nx;
          if (alu_sat) sat_flag <= 1'b1;
        end
        if (s == S_LAST) begin
          out_valid <= 1'b1;
          out_ch    <= ch;
          out_data  <= ch_bad ? '0 : DW'(sat_fn(64'(acc_nx), DW));
          if (!ch_bad && is_sat(64'(acc_nx), DW)) sat_flag <= 1'b1;
        end else begin
          s <= s + 1'b1;
        end
      end
    end
  end

  // Coefficients survive flush; only reset restores the passthrough set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int st = 0; st < STG; st++) begin
        for (int k = 0; k < NCOEF; k++) begin
          coef[st][k] <= (k == int'(C_B0) || k == int'(C_G)) ? UNITY : '0;
        end
      end
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) coef[cfg_stage][cfg_idx] <= $signed(cfg_data);
        else        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iir_mc_cascade.sv
module tb_iir_mc_cascade;
  import iir_mc_pkg::*;

  localparam int DW = 16, EW = 4, W = 20, CW = 18, CFW = 14, STG = 3, CH = 4;
  localparam int CHW = 2, SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [DW-1:0] in_data = '0;
  logic out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0] out_data;
  logic cfg_we = 1'b0;
  logic [SW+2:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_err;
  logic flush = 1'b0;
  logic sat_flag;

  always #5 clk = ~clk;

  iir_mc_cascade #(.DW(DW), .EW(EW), .CW(CW), .CFW(CFW), .STG(STG), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .flush(flush), .sat_flag(sat_flag)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: coefficients, per-channel per-stage state, sticky sat.
  longint mc [STG][6];
  longint mz0 [CH][STG];
  longint mz1 [CH][STG];
  bit msat;

  function automatic longint clamp(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin msat = 1'b1; return hi; end
    if (v < lo) begin msat = 1'b1; return lo; end
    return v;
  endfunction

  function automatic longint fx(input longint c, input longint v);
    return (c * v) >>> CFW;
  endfunction

  task automatic model_sample(input int c, input longint xin, output longint y);
    longint x, o, n0, n1;
    x = xin;
    for (int st = 0; st < STG; st++) begin
      o  = clamp(fx(mc[st][0], x) + mz0[c][st], W);
      n0 = clamp(fx(mc[st][1], x) - fx(mc[st][3], o) + mz1[c][st], W);
      n1 = clamp(fx(mc[st][2], x) - fx(mc[st][4], o), W);
      x  = clamp(fx(mc[st][5], o), W);
      mz0[c][st] = n0;
      mz1[c][st] = n1;
    end
    y = clamp(x, DW);
  endtask

  task automatic model_flush();
    for (int c = 0; c < CH; c++)
      for (int st = 0; st < STG; st++) begin
        mz0[c][st] = 0;
        mz1[c][st] = 0;
      end
    msat = 1'b0;
  endtask

  task automatic model_reset();
    for (int st = 0; st < STG; st++)
      for (int k = 0; k < 6; k++)
        mc[st][k] = (k == 0 || k == 5) ? longint'(COEF_UNITY) : 0;
    model_flush();
  endtask

  task automatic cfg_write(input int st, input int idx, input int val);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = {st[SW-1:0], idx[2:0]};
    cfg_data = val[CW-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    if (st < STG && idx <= 5) mc[st][idx] = val;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
  endtask

  task automatic run_sample(input int c, input int d, output int got, output int gch,
                            output int lat, output int rlow, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch = c[CHW-1:0];
    in_data = d[DW-1:0];
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0; lat = 1; rlow = 0; got = 0; gch = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (!in_ready) rlow++;
      if (out_valid) begin
        ok = 1'b1;
        got = $signed(out_data);
        gch = out_ch;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_passthrough();
    int got, gch, lat, rlow, c, d; bit ok; longint y;
    run_sample(0, 1000, got, gch, lat, rlow, ok);
    model_sample(0, 1000, y);
    n_vec++; if (!ok || got != 1000) begin n_err++; $display("FAIL pass_data: got %0d (valid %b) want 1000", got, ok); end
    n_vec++; if (gch != 0) begin n_err++; $display("FAIL pass_ch: got %0d want 0", gch); end
    n_vec++; if (lat != STG + 1) begin n_err++; $display("FAIL pass_latency: got %0d want %0d", lat, STG + 1); end
    n_vec++; if (rlow != STG) begin n_err++; $display("FAIL pass_ready_low: got %0d want %0d", rlow, STG); end
    for (int k = 0; k < 8; k++) begin
      c = $urandom_range(0, CH - 1);
      d = int'($urandom_range(0, 65535)) - 32768;
      run_sample(c, d, got, gch, lat, rlow, ok);
      model_sample(c, d, y);
      n_vec++; if (!ok || got != int'(y) || gch != c) begin
        n_err++; $display("FAIL pass_rand: got %0d ch %0d want %0d ch %0d", got, gch, y, c);
      end
    end
  endtask

  task automatic test_half_gain();
    int got, gch, lat, rlow; bit ok; longint y;
    cfg_write(0, 0, 8192);
    run_sample(1, 1000, got, gch, lat, rlow, ok);
    model_sample(1, 1000, y);
    n_vec++; if (!ok || got != 500) begin n_err++; $display("FAIL half_pos: got %0d want 500", got); end
    repeat (2) @(negedge clk);
    n_vec++; if ($signed(out_data) != 500) begin n_err++; $display("FAIL half_hold: got %0d want 500", $signed(out_data)); end
    run_sample(1, -1001, got, gch, lat, rlow, ok);
    model_sample(1, -1001, y);
    n_vec++; if (!ok || got != -501) begin n_err++; $display("FAIL half_floor: got %0d want -501", got); end
  endtask

  task automatic test_pole();
    int got, gch, lat, rlow; bit ok; longint y;
    int exp_ir [4] = '{16000, 8000, 4000, 2000};
    cfg_write(0, 0, 16384);
    cfg_write(0, 3, -8192);
    do_flush();
    for (int k = 0; k < 4; k++) begin
      run_sample(2, (k == 0) ? 16000 : 0, got, gch, lat, rlow, ok);
      model_sample(2, (k == 0) ? 16000 : 0, y);
      n_vec++; if (!ok || got != exp_ir[k] || gch != 2) begin
        n_err++; $display("FAIL pole_ir%0d: got %0d ch %0d want %0d ch 2", k, got, gch, exp_ir[k]);
      end
      run_sample(1, 0, got, gch, lat, rlow, ok);
      model_sample(1, 0, y);
      n_vec++; if (!ok || got != 0 || gch != 1) begin
        n_err++; $display("FAIL pole_ch1_%0d: got %0d ch %0d want 0 ch 1", k, got, gch);
      end
    end
  endtask

  task automatic test_random();
    int got, gch, lat, rlow, c, d; bit ok; longint y;
    cfg_write(1, 1, int'($urandom_range(0, 8192)) - 4096);
    cfg_write(1, 4, int'($urandom_range(0, 4000)) - 2000);
    cfg_write(2, 5, int'($urandom_range(8192, 24576)));
    for (int k = 0; k < 20; k++) begin
      c = $urandom_range(0, CH - 1);
      d = int'($urandom_range(0, 65535)) - 32768;
      run_sample(c, d, got, gch, lat, rlow, ok);
      model_sample(c, d, y);
      n_vec++; if (!ok || got != int'(y) || gch != c) begin
        n_err++; $display("FAIL rand_out%0d: got %0d ch %0d want %0d ch %0d", k, got, gch, y, c);
      end
      n_vec++; if (sat_flag !== msat) begin
        n_err++; $display("FAIL rand_sat%0d: got %b want %b", k, sat_flag, msat);
      end
    end
    cfg_write(1, 1, 0);
    cfg_write(1, 4, 0);
    cfg_write(2, 5, 16384);
    do_flush();
  endtask

  task automatic test_saturation();
    int got, gch, lat, rlow; bit ok; longint y;
    cfg_write(0, 3, 0);
    for (int st = 0; st < STG; st++) cfg_write(st, 0, 65536);
    do_flush();
    run_sample(0, 10000, got, gch, lat, rlow, ok);
    model_sample(0, 10000, y);
    n_vec++; if (!ok || got != 32767) begin n_err++; $display("FAIL sat_pos: got %0d want 32767", got); end
    n_vec++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
    do_flush();
    n_vec++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_flag_flush: got %b want 0", sat_flag); end
    run_sample(3, -10000, got, gch, lat, rlow, ok);
    model_sample(3, -10000, y);
    n_vec++; if (!ok || got != -32768) begin n_err++; $display("FAIL sat_neg: got %0d want -32768", got); end
    for (int st = 0; st < STG; st++) cfg_write(st, 0, 16384);
    do_flush();
  endtask

  task automatic test_cfg_err();
    int got, gch, lat, rlow; bit ok; longint y;
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'd1200;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 5'b00_000; cfg_data = '0;
    @(negedge clk);
    cfg_we = 1'b0;
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_busy_err: got %b want 1", cfg_err); end
    @(negedge clk);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_busy_once: got %b want 0", cfg_err); end
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (out_valid) begin ok = 1'b1; got = $signed(out_data); end
      else @(negedge clk);
    end
    model_sample(3, 1200, y);
    n_vec++; if (!ok || got != int'(y)) begin n_err++; $display("FAIL cfg_busy_result: got %0d want %0d", got, y); end
    cfg_write(0, 6, 0);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_idx6_err: got %b want 1", cfg_err); end
    @(negedge clk);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_idx6_once: got %b want 0", cfg_err); end
    cfg_write(3, 0, 0);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_stage3_err: got %b want 1", cfg_err); end
    run_sample(3, 1200, got, gch, lat, rlow, ok);
    model_sample(3, 1200, y);
    n_vec++; if (!ok || got != 1200 || got != int'(y)) begin n_err++; $display("FAIL cfg_unchanged: got %0d want 1200", got); end
  endtask

  task automatic test_flush_run();
    int got, gch, lat, rlow, seen; bit ok; longint y;
    cfg_write(0, 3, -8192);
    do_flush();
    run_sample(2, 16000, got, gch, lat, rlow, ok);
    model_sample(2, 16000, y);
    n_vec++; if (!ok || got != 16000) begin n_err++; $display("FAIL flush_pre: got %0d want 16000", got); end
    // abort right after accept
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd2; in_data = '0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_back: got %b want 1", in_ready); end
    model_flush();
    seen = 0;
    // flush colliding with in_valid, then with the completing stage
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd5000;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd7000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin if (out_valid) seen++; @(negedge clk); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) begin if (out_valid) seen++; @(negedge clk); end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_out: got %0d pulses want 0", seen); end
    run_sample(2, 16000, got, gch, lat, rlow, ok);
    model_sample(2, 16000, y);
    n_vec++; if (!ok || got != 16000) begin n_err++; $display("FAIL flush_restart: got %0d want 16000", got); end
    run_sample(2, 0, got, gch, lat, rlow, ok);
    model_sample(2, 0, y);
    n_vec++; if (!ok || got != 8000) begin n_err++; $display("FAIL flush_tail: got %0d want 8000", got); end
  endtask

  task automatic test_reset_run();
    int got, gch, lat, rlow; bit ok; longint y;
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd2; in_data = 16'd16000;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== 16'd0 || out_ch !== 2'd0) begin
      n_err++; $display("FAIL rrun_outs: got valid %b data %0d ch %0d want 0 0 0", out_valid, out_data, out_ch);
    end
    n_vec++; if (cfg_err !== 1'b0 || sat_flag !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rrun_flags: got err %b sat %b rdy %b want 0 0 1", cfg_err, sat_flag, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_sample(2, 1234, got, gch, lat, rlow, ok);
    model_sample(2, 1234, y);
    n_vec++; if (!ok || got != 1234) begin n_err++; $display("FAIL rrun_pass: got %0d want 1234", got); end
    run_sample(2, 0, got, gch, lat, rlow, ok);
    model_sample(2, 0, y);
    n_vec++; if (!ok || got != 0) begin n_err++; $display("FAIL rrun_nopole: got %0d want 0", got); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_half_gain();
    test_pole();
    test_random();
    test_saturation();
    test_cfg_err();
    test_flush_run();
    test_reset_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
